// File: rtl/game_pkg.sv
// Shared types and helpers for the artillery turn sequencer.
// Holds the turn state encoding, field widths and hp arithmetic.
package game_pkg;

    localparam int HP_W   = 7;
    localparam int TIME_W = 6;

    typedef logic player_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AIM     = 3'd1,
        ST_FLIGHT  = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_SWITCH  = 3'd4,
        ST_OVER    = 3'd5
    } turn_state_t;

    // Saturating subtract so hp bottoms out at zero instead of wrapping.
    function automatic logic [HP_W-1:0] hp_sub(
        input logic [HP_W-1:0] hp,
        input logic [HP_W-1:0] dmg
    );
        return (hp > dmg) ? (hp - dmg) : '0;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: one-cycle tick every TICKS_PER_SEC clocks.
// Clear restarts the second so a new turn phase gets a full first second.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    // Free-running modulo counter, restarted by reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/turn_ctl.sv
// Turn sequencer: game FSM, aim countdown, flight timeout and hit points.
// Emits launch to the projectile engine and next_turn to the wind generator.
module turn_ctl
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 65_000_000,
    parameter int TURN_TIME      = 20,
    parameter int FLIGHT_TIMEOUT = 8,
    parameter int HP_MAX         = 100,
    parameter int DAMAGE         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fire,
    input  logic       proj_done,
    input  logic       proj_hit,
    output logic       launch,
    output logic       next_turn,
    output logic       active_player,
    output logic [5:0] time_left,
    output logic [6:0] hp0,
    output logic [6:0] hp1,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    localparam logic [HP_W-1:0]   HP_INIT  = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]   HP_DMG   = HP_W'(DAMAGE);
    localparam logic [TIME_W-1:0] AIM_SECS = TIME_W'(TURN_TIME);
    localparam logic [TIME_W-1:0] FLT_LAST = TIME_W'(FLIGHT_TIMEOUT - 1);

    turn_state_t st, st_n;
    player_t     player_n;
    logic [TIME_W-1:0] time_n;
    logic [TIME_W-1:0] fsec, fsec_n;
    logic [HP_W-1:0]   hp0_n, hp1_n;
    logic [HP_W-1:0]   opp_hp, opp_left;
    logic winner_n, game_over_n, launch_n, next_turn_n;
    logic hit, hit_n;
    logic start_q, fire_q;
    logic start_edge, fire_edge;
    logic enter_aim, enter_flight, clear;
    logic sec_tick;

    assign start_edge = start & ~start_q;
    assign fire_edge  = fire & ~fire_q;
    assign state      = st;

    assign opp_hp   = active_player ? hp0 : hp1;
    assign opp_left = hp_sub(opp_hp, HP_DMG);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (sec_tick)
    );

    // Input edge detectors for the level-sensitive buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            start_q <= start;
            fire_q  <= fire;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= ST_IDLE;
            active_player <= 1'b0;
            time_left     <= '0;
            fsec          <= '0;
            hit           <= 1'b0;
            hp0           <= HP_INIT;
            hp1           <= HP_INIT;
            winner        <= 1'b0;
            game_over     <= 1'b0;
            launch        <= 1'b0;
            next_turn     <= 1'b0;
        end else begin
            st            <= st_n;
            active_player <= player_n;
            time_left     <= time_n;
            fsec          <= fsec_n;
            hit           <= hit_n;
            hp0           <= hp0_n;
            hp1           <= hp1_n;
            winner        <= winner_n;
            game_over     <= game_over_n;
            launch        <= launch_n;
            next_turn     <= next_turn_n;
        end
    end

    // Next-state and next-output decode for the turn sequence.
    always_comb begin
        st_n        = st;
        player_n    = active_player;
        time_n      = time_left;
        fsec_n      = fsec;
        hit_n       = hit;
        hp0_n       = hp0;
        hp1_n       = hp1;
        winner_n    = winner;
        launch_n    = 1'b0;

        unique case (st)
            ST_IDLE: begin
                if (start_edge) begin
                    st_n     = ST_AIM;
                    hp0_n    = HP_INIT;
                    hp1_n    = HP_INIT;
                    player_n = 1'b0;
                end
            end
            ST_AIM: begin
                if (fire_edge) begin
                    st_n     = ST_FLIGHT;
                    launch_n = 1'b1;
                    fsec_n   = '0;
                end else if (time_left == '0) begin
                    st_n = ST_SWITCH;
                end else if (sec_tick) begin
                    time_n = time_left - TIME_W'(1);
                end
            end
            ST_FLIGHT: begin
                if (proj_done) begin
                    st_n  = ST_RESOLVE;
                    hit_n = proj_hit;
                end else if (sec_tick) begin
                    if (fsec == FLT_LAST) begin
                        st_n  = ST_RESOLVE;
                        hit_n = 1'b0;
                    end else begin
                        fsec_n = fsec + TIME_W'(1);
                    end
                end
            end
            ST_RESOLVE: begin
                st_n = ST_SWITCH;
                if (hit) begin
                    if (active_player) begin
                        hp0_n = opp_left;
                    end else begin
                        hp1_n = opp_left;
                    end
                    if (opp_left == '0) begin
                        st_n     = ST_OVER;
                        winner_n = active_player;
                    end
                end
            end
            ST_SWITCH: begin
                player_n = ~active_player;
                st_n     = ST_AIM;
            end
            ST_OVER: begin
                if (start_edge) begin
                    st_n     = ST_AIM;
                    hp0_n    = HP_INIT;
                    hp1_n    = HP_INIT;
                    player_n = 1'b0;
                end
            end
            default: begin
                st_n = ST_IDLE;
            end
        endcase

        enter_aim    = (st_n == ST_AIM) && (st != ST_AIM);
        enter_flight = (st_n == ST_FLIGHT) && (st != ST_FLIGHT);
        if (enter_aim) begin
            time_n = AIM_SECS;
        end
        next_turn_n = enter_aim;
        game_over_n = (st_n == ST_OVER);
        clear       = enter_aim || enter_flight;
    end

endmodule

// File: tb/tb_turn_ctl.sv
// Directed bench for turn_ctl with small timing parameters.
// Expected values are worked out by hand from the turn rules.
module tb_turn_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       fire;
    logic       proj_done;
    logic       proj_hit;
    logic       launch;
    logic       next_turn;
    logic       active_player;
    logic [5:0] time_left;
    logic [6:0] hp0;
    logic [6:0] hp1;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_launch = 0;
    int n_turn   = 0;
    int snap_l;
    int snap_t;

    localparam int S_IDLE = 0, S_AIM = 1, S_FLT = 2, S_RES = 3,
                   S_SW = 4, S_OVER = 5;

    turn_ctl #(
        .TICKS_PER_SEC (4),
        .TURN_TIME     (3),
        .FLIGHT_TIMEOUT(2),
        .HP_MAX        (10),
        .DAMAGE        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fire         (fire),
        .proj_done    (proj_done),
        .proj_hit     (proj_hit),
        .launch       (launch),
        .next_turn    (next_turn),
        .active_player(active_player),
        .time_left    (time_left),
        .hp0          (hp0),
        .hp1          (hp1),
        .game_over    (game_over),
        .winner       (winner),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (launch) n_launch++;
        if (next_turn) n_turn++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // fire edge, then a landed hit; ends one cycle after RESOLVE
    task automatic do_hit();
        fire = 1'b1;
        step(1);
        fire = 1'b0;
        proj_done = 1'b1;
        proj_hit  = 1'b1;
        step(1);
        proj_done = 1'b0;
        proj_hit  = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fire = 1'b0;
        proj_done = 1'b0;
        proj_hit = 1'b0;

        // 1. reset
        step(3);
        check("rst_state", state, S_IDLE);
        check("rst_hp0", hp0, 10);
        check("rst_hp1", hp1, 10);
        check("rst_time", time_left, 0);
        check("rst_player", active_player, 0);
        check("rst_launch", launch, 0);
        check("rst_nturn", next_turn, 0);
        check("rst_over", game_over, 0);
        rst = 1'b0;
        step(1);
        check("idle_hold", state, S_IDLE);

        // 2. start, fire, hit
        start = 1'b1;
        step(1);
        check("t2_aim", state, S_AIM);
        check("t2_nturn_hi", next_turn, 1);
        check("t2_time", time_left, 3);
        check("t2_player", active_player, 0);
        step(1);
        check("t2_nturn_lo", next_turn, 0);
        start = 1'b0;
        fire = 1'b1;
        step(1);
        check("t2_flight", state, S_FLT);
        check("t2_launch_hi", launch, 1);
        step(1);
        check("t2_launch_lo", launch, 0);
        fire = 1'b0;
        proj_done = 1'b1;
        proj_hit = 1'b1;
        step(1);
        proj_done = 1'b0;
        proj_hit = 1'b0;
        check("t2_resolve", state, S_RES);
        check("t2_nturn_r", next_turn, 0);
        step(1);
        check("t2_switch", state, S_SW);
        check("t2_hp1", hp1, 6);
        check("t2_hp0", hp0, 10);
        step(1);
        check("t2_aim2", state, S_AIM);
        check("t2_nturn2", next_turn, 1);
        check("t2_player2", active_player, 1);
        check("t2_time2", time_left, 3);

        // 3. aim timeout countdown
        snap_l = n_launch;
        step(3);
        check("t3_time_a", time_left, 3);
        step(1);
        check("t3_time_b", time_left, 2);
        step(4);
        check("t3_time_c", time_left, 1);
        step(4);
        check("t3_time_d", time_left, 0);
        check("t3_still_aim", state, S_AIM);
        step(1);
        check("t3_switch", state, S_SW);
        step(1);
        check("t3_aim", state, S_AIM);
        check("t3_player", active_player, 0);
        check("t3_nturn", next_turn, 1);
        check("t3_no_launch", n_launch, snap_l);

        // 4. play to game over
        do_hit();
        check("t4_hp1_2", hp1, 2);
        step(1);
        check("t4_p1", active_player, 1);
        step(14);
        check("t4_back_p0", active_player, 0);
        check("t4_back_aim", state, S_AIM);
        do_hit();
        check("t4_over", state, S_OVER);
        check("t4_hp1_0", hp1, 0);
        check("t4_gover", game_over, 1);
        check("t4_winner", winner, 0);
        snap_l = n_launch;
        fire = 1'b1;
        proj_done = 1'b1;
        proj_hit = 1'b1;
        step(3);
        fire = 1'b0;
        proj_done = 1'b0;
        proj_hit = 1'b0;
        check("t4_ign_state", state, S_OVER);
        check("t4_ign_hp1", hp1, 0);
        check("t4_ign_launch", n_launch, snap_l);
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t4_rs_state", state, S_AIM);
        check("t4_rs_hp0", hp0, 10);
        check("t4_rs_hp1", hp1, 10);
        check("t4_rs_player", active_player, 0);
        check("t4_rs_gover", game_over, 0);
        check("t4_rs_nturn", next_turn, 1);

        // 5/6. held fire, flight timeout miss, stray proj_done
        snap_l = n_launch;
        fire = 1'b1;
        step(1);
        check("t5_launch", launch, 1);
        step(7);
        check("t5_in_flight", state, S_FLT);
        step(1);
        check("t6_timeout", state, S_RES);
        step(1);
        check("t6_switch", state, S_SW);
        check("t6_hp0", hp0, 10);
        check("t6_hp1", hp1, 10);
        step(1);
        check("t6_aim", state, S_AIM);
        check("t6_player", active_player, 1);
        step(3);
        check("t5_one_launch", n_launch, snap_l + 1);
        check("t5_held_aim", state, S_AIM);
        fire = 1'b0;
        proj_done = 1'b1;
        proj_hit = 1'b1;
        step(1);
        proj_done = 1'b0;
        proj_hit = 1'b0;
        step(1);
        check("t5_stray_hp0", hp0, 10);
        check("t5_stray_hp1", hp1, 10);
        check("t5_stray_st", state, S_AIM);

        // 6b. reset mid-flight
        fire = 1'b1;
        step(1);
        check("t6_flt", state, S_FLT);
        step(2);
        rst = 1'b1;
        snap_l = n_launch;
        snap_t = n_turn;
        step(1);
        check("t6_rst_state", state, S_IDLE);
        check("t6_rst_hp1", hp1, 10);
        check("t6_rst_time", time_left, 0);
        rst = 1'b0;
        step(3);
        check("t6_rst_idle", state, S_IDLE);
        check("t6_rst_nol", n_launch, snap_l);
        check("t6_rst_not", n_turn, snap_t);

        // fire edge on the cycle time_left hits zero
        fire = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("tz_aim", state, S_AIM);
        step(12);
        check("tz_time0", time_left, 0);
        fire = 1'b1;
        step(1);
        fire = 1'b0;
        check("tz_fire_wins", state, S_FLT);
        check("tz_launch", launch, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_ctl.md
Name: turn_ctl

Overview:
- Turn sequencer for the two-player artillery game.
- Owns the game state machine, active-player selection, per-turn aim countdown and player hit points.
- Issues the one-cycle `next_turn` pulse that advances the wind generator, and the `launch` pulse to the projectile engine.
- Sits between the input/button logic and the projectile/wind/draw datapath.

Parameters:
- TICKS_PER_SEC, 65_000_000, clock cycles per second of countdown.
- TURN_TIME, 20, aim seconds per turn (1..63).
- FLIGHT_TIMEOUT, 8, max flight seconds before forced miss (1..63).
- HP_MAX, 100, starting hit points (1..127).
- DAMAGE, 25, hp removed per hit (1..127).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  level; rising edge starts/restarts game from IDLE or OVER
- fire  in  1  level; rising edge fires in AIM
- proj_done  in  1  one-cycle pulse: projectile landed/left screen
- proj_hit  in  1  sampled with proj_done: 1 = opponent hit
- launch  out  1  one-cycle pulse: start projectile for active_player
- next_turn  out  1  one-cycle pulse to wind generator on every AIM entry
- active_player  out  1  0/1
- time_left  out  6  aim seconds remaining
- hp0, hp1  out  7  hit points
- game_over  out  1  high in OVER
- winner  out  1  valid when game_over
- state  out  3  current turn_state_t (debug/draw)

Behaviour:
- All outputs registered; clock and reset are as stated in the interface.
- Reset (synchronous, active-high): state=IDLE, active_player=0, time_left=0, hp0=hp1=HP_MAX, launch=next_turn=game_over=winner=0, prescaler=0, edge registers=0.
- Edge detection: start, fire registered internally; action on 0->1 only. Held levels never retrigger.
- Second tick: prescaler counts 0..TICKS_PER_SEC-1, wraps producing sec_tick. Cleared on entry to AIM and FLIGHT.
- States: IDLE, AIM, FLIGHT, RESOLVE, SWITCH, OVER.
- IDLE: start edge -> AIM; hp0=hp1=HP_MAX, active_player=0.
- AIM entry (from any state): time_left=TURN_TIME, next_turn=1 for exactly that one cycle.
- AIM: sec_tick decrements time_left.
  - fire edge -> FLIGHT, launch=1 one cycle.
  - time_left==0 -> SWITCH, no launch.
  - fire edge and time_left==0 in the same cycle: fire wins.
- FLIGHT: flight-second counter from 0; fire ignored.
  - proj_done -> RESOLVE, latch proj_hit.
  - Counter reaches FLIGHT_TIMEOUT with no proj_done -> RESOLVE with hit=0.
- RESOLVE, one cycle: if hit, opponent hp = max(hp-DAMAGE, 0), saturating, never wraps.
  - Resulting hp==0 -> OVER, winner=active_player.
  - Otherwise -> SWITCH.
- SWITCH, one cycle: toggle active_player -> AIM.
- OVER: game_over=1; hp and winner hold; fire/proj_done ignored.
  - start edge -> AIM with hp reset, active_player=0, game_over=0.
- proj_done outside FLIGHT ignored.
- rst in any state, including mid-FLIGHT, returns to reset values next edge; no launch/next_turn emitted.
- Latencies:
  - fire edge -> launch: 1 cycle.
  - proj_done -> next_turn (non-final): 3 cycles (RESOLVE, SWITCH, AIM).

Decomposition:
- game_pkg: turn_state_t enum (3-bit), HP_W=7, TIME_W=6, player index type.
- Sub-module sec_tick_gen: prescaler with clear input and one-cycle tick output, parameter TICKS_PER_SEC.

Test Plan (TICKS_PER_SEC=4, TURN_TIME=3, FLIGHT_TIMEOUT=2, HP_MAX=10, DAMAGE=4):
1. Reset held 3 cycles -> state=IDLE, hp0=hp1=10, time_left=0, active_player=0, launch=next_turn=game_over=0.
2. start edge -> AIM, next_turn high exactly 1 cycle, time_left=3, player 0. fire edge -> launch 1 cycle. proj_done+proj_hit=1 -> hp1=6; 3 cycles later next_turn pulse, active_player=1, time_left=3.
3. AIM with no fire -> time_left 3,2,1,0 at 4-cycle spacing; then SWITCH, player toggles, next_turn pulses, launch never asserted.
4. Player 0 hits three times (player 1 times out between) -> hp1 10,6,2,0 (saturates, not 126); game_over=1, winner=0. fire/proj_done ignored. start edge -> hp0=hp1=10, AIM, player 0.
5. fire held high through entire turn and into next AIM -> single launch only. Extra proj_done during AIM -> no hp change.
6. Launch, no proj_done -> after 8 cycles RESOLVE as miss, hp unchanged, SWITCH. Separately rst mid-FLIGHT -> IDLE, hp=10, no pulses.
